// File: rtl/vga_pkg.sv
// Shared definitions for the VGA drawing blocks: mode encodings, default
// screen geometry and the background-to-colour expansion helper.
package vga_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int EXPAND_W     = 32;

    typedef enum logic [1:0] {
        MODE_FILL   = 2'd0,
        MODE_COPY   = 2'd1,
        MODE_INVERT = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // A 1-bit background value is replicated across the colour; wider data passes through.
    function automatic logic [EXPAND_W-1:0] expand_color(input logic [EXPAND_W-1:0] bg,
                                                         input int unsigned bg_w);
        return (bg_w == 1) ? {EXPAND_W{bg[0]}} : bg;
    endfunction

endpackage

// File: rtl/rect_fill_engine_if.sv
// Pixel write bus from the fill engine to the framebuffer, with backpressure.
interface rect_fill_engine_if #(
    parameter int XW      = 8,
    parameter int COLOR_W = 12
);
    logic [XW-1:0]      pix_x;
    logic [XW-1:0]      pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic               pix_we;
    logic               pix_ready;

    modport master (output pix_x, pix_y, pix_color, pix_we, input pix_ready);
    modport slave  (input pix_x, pix_y, pix_color, pix_we, output pix_ready);
endinterface

// File: rtl/rect_fill_engine_pix_fifo.sv
// Small synchronous FIFO (any depth) with occupancy count and a flush input
// that empties it in one cycle.
module pix_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage has no reset; stale entries are never visible because reads are qualified by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Clipped rectangle fill/copy/invert engine: raster issue with credit-based
// flow control, a ROM-latency matching pipe and a backpressured pixel FIFO.
module rect_fill_engine
    import vga_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int XW       = 8,
    parameter int COLOR_W  = 12,
    parameter int BG_W     = 1,
    parameter int ADDR_W   = 15,
    parameter int ROM_LAT  = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [XW-1:0]      x0,
    input  logic [XW-1:0]      y0,
    input  logic [XW-1:0]      w,
    input  logic [XW-1:0]      h,
    input  logic [COLOR_W-1:0] fill_color,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  bg_addr,
    input  logic [BG_W-1:0]    bg_q,
    rect_fill_engine_if.master pix
);

    localparam int FIFO_D = ROM_LAT + 2;
    localparam int CW     = $clog2(FIFO_D + 1);
    localparam int FW     = 2 * XW + COLOR_W;
    localparam logic [XW:0] SW_X = (XW + 1)'(SCREEN_W);
    localparam logic [XW:0] SH_Y = (XW + 1)'(SCREEN_H);

    state_e             state, state_nx;
    mode_e              mode_r;
    logic [COLOR_W-1:0] color_r;
    logic [XW-1:0]      x0_r, x_cnt, y_cnt;
    logic [XW:0]        xe_r, ye_r;
    logic               done_r;

    logic [ROM_LAT-1:0] vld_pipe;
    logic [XW-1:0]      x_pipe [ROM_LAT];
    logic [XW-1:0]      y_pipe [ROM_LAT];

    logic [XW:0]        x_sum, y_sum, xe_in, ye_in;
    logic               empty_rect, start_ok, issue, x_wrap, last_issue;
    logic               pipe_empty, drain_fin, credit_ok;
    int                 in_flight;
    logic [COLOR_W-1:0] bg_exp, pipe_color;

    logic               fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CW-1:0]      fifo_count;
    logic [FW-1:0]      fifo_head;

    // Extent is clipped in XW+1 bits so x0+w never wraps.
    assign x_sum      = {1'b0, x0} + {1'b0, w};
    assign y_sum      = {1'b0, y0} + {1'b0, h};
    assign xe_in      = (x_sum > SW_X) ? SW_X : x_sum;
    assign ye_in      = (y_sum > SH_Y) ? SH_Y : y_sum;
    assign empty_rect = (w == '0) || (h == '0) || ({1'b0, x0} >= SW_X) || ({1'b0, y0} >= SH_Y);

    assign start_ok   = (state == ST_IDLE) && start && !abort;
    assign pipe_empty = (vld_pipe == '0);
    assign fifo_pop   = !fifo_empty && pix.pix_ready;
    assign x_wrap     = (({1'b0, x_cnt} + 1'b1) == xe_r);
    assign issue      = (state == ST_RUN) && !abort && credit_ok;
    assign last_issue = issue && x_wrap && (({1'b0, y_cnt} + 1'b1) == ye_r);
    assign drain_fin  = (state == ST_DRAIN) && pipe_empty &&
                        (fifo_empty || ((fifo_count == CW'(1)) && fifo_pop));
    assign bg_addr    = ADDR_W'(y_cnt) * ADDR_W'(SCREEN_W) + ADDR_W'(x_cnt);

    // Credits cover both the ROM pipe and the FIFO, so a push can never find the FIFO full.
    always_comb begin
        in_flight = $countones(vld_pipe);
        credit_ok = (in_flight + int'(fifo_count)) < FIFO_D;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nx;
    end

    // NOTE: next-state is defaulted first so every path assigns it and no latch is inferred.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start_ok && !empty_rect) state_nx = ST_RUN;
            ST_RUN:   if (abort) state_nx = ST_IDLE;
                      else if (last_issue) state_nx = ST_DRAIN;
            ST_DRAIN: if (abort || drain_fin) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != ST_IDLE);
        done          = done_r;
        pix.pix_we    = !fifo_empty;
        {pix.pix_x, pix.pix_y, pix.pix_color} = fifo_empty ? '0 : fifo_head;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_r  <= MODE_FILL;
            color_r <= '0;
            x0_r    <= '0;
            xe_r    <= '0;
            ye_r    <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= (start_ok && empty_rect) || (drain_fin && !abort);
            if (start_ok) begin
                mode_r  <= (mode == MODE_COPY || mode == MODE_INVERT) ? mode_e'(mode) : MODE_FILL;
                color_r <= fill_color;
                x0_r    <= x0;
                xe_r    <= xe_in;
                ye_r    <= ye_in;
                x_cnt   <= x0;
                y_cnt   <= y0;
            end else if (issue) begin
                if (x_wrap) begin
                    x_cnt <= x0_r;
                    y_cnt <= y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                x_pipe[i] <= '0;
                y_pipe[i] <= '0;
            end
        end else if (abort) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue;
            x_pipe[0]   <= x_cnt;
            y_pipe[0]   <= y_cnt;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                x_pipe[i]   <= x_pipe[i-1];
                y_pipe[i]   <= y_pipe[i-1];
            end
        end
    end

    always_comb begin
        bg_exp = COLOR_W'(expand_color(EXPAND_W'(bg_q), BG_W));
        unique case (mode_r)
            MODE_COPY:   pipe_color = bg_exp;
            MODE_INVERT: pipe_color = ~bg_exp;
            default:     pipe_color = color_r;
        endcase
    end

    assign fifo_push = vld_pipe[ROM_LAT-1] && !abort;

    pix_fifo #(.DEPTH(FIFO_D), .WIDTH(FW)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (abort),
        .push   (fifo_push),
        .wdata  ({x_pipe[ROM_LAT-1], y_pipe[ROM_LAT-1], pipe_color}),
        .pop    (fifo_pop),
        .rdata  (fifo_head),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (fifo_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed self-checking bench for rect_fill_engine with a behavioural
// background ROM and a raster-order pixel scoreboard.
module tb_rect_fill_engine;
    import vga_pkg::*;

    localparam int XW = 8, COLOR_W = 12, BG_W = 1, ADDR_W = 15, ROM_LAT = 2;
    localparam int SW = 160, SH = 120;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic [XW-1:0]      x0 = '0, y0 = '0, w = '0, h = '0;
    logic [COLOR_W-1:0] fill_color = '0;
    logic               busy, done;
    logic [ADDR_W-1:0]  bg_addr;
    logic [BG_W-1:0]    bg_q;

    rect_fill_engine_if #(.XW(XW), .COLOR_W(COLOR_W)) pix_bus ();

    rect_fill_engine #(
        .SCREEN_W(SW), .SCREEN_H(SH), .XW(XW), .COLOR_W(COLOR_W),
        .BG_W(BG_W), .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .x0         (x0),
        .y0         (y0),
        .w          (w),
        .h          (h),
        .fill_color (fill_color),
        .busy       (busy),
        .done       (done),
        .bg_addr    (bg_addr),
        .bg_q       (bg_q),
        .pix        (pix_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic rom_bit(input logic [ADDR_W-1:0] a);
        return a[0] ^ a[2] ^ a[5] ^ a[9];
    endfunction

    // Behavioural ROM: data for an address appears ROM_LAT cycles later.
    logic [ADDR_W-1:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= bg_addr;
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bg_q = rom_bit(rom_pipe[ROM_LAT-1]);

    int rmode = 0;
    initial begin
        pix_bus.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_bus.pix_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic [27:0] acc_q [$];
    int          done_cnt = 0, busy_cnt = 0, we_cnt = 0;
    logic        hold_chk = 1'b0;
    logic        stall_prev = 1'b0;
    logic [28:0] prev_out, cur_out;

    always @(negedge clk) begin
        cur_out = {pix_bus.pix_we, pix_bus.pix_x, pix_bus.pix_y, pix_bus.pix_color};
        if (resetn && hold_chk && stall_prev) check("stall_hold", 64'(cur_out), 64'(prev_out));
        stall_prev = resetn && pix_bus.pix_we && !pix_bus.pix_ready;
        prev_out   = cur_out;
        if (resetn && pix_bus.pix_we && pix_bus.pix_ready)
            acc_q.push_back({pix_bus.pix_x, pix_bus.pix_y, pix_bus.pix_color});
        if (done)           done_cnt++;
        if (busy)           busy_cnt++;
        if (pix_bus.pix_we) we_cnt++;
    end

    task automatic start_job(input logic [1:0] m, input int ax, input int ay, input int aw,
                             input int ah, input logic [11:0] c, output int t);
        @(posedge clk);
        #1;
        mode = m; x0 = 8'(ax); y0 = 8'(ay); w = 8'(aw); h = 8'(ah); fill_color = c;
        start = 1'b1;
        t = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        check({tag, "_done_seen"}, 64'(dcyc >= 0), 64'd1);
    endtask

    task automatic verify_rect(input string tag, input int base, input int ax, input int ay,
                               input int aw, input int ah, input logic [1:0] m,
                               input logic [11:0] c, input int n_exp);
        int          xe, ye, idx, nbad;
        logic        b;
        logic [11:0] col;
        logic [27:0] exp_pix;
        xe = (ax + aw > SW) ? SW : ax + aw;
        ye = (ay + ah > SH) ? SH : ay + ah;
        check({tag, "_count"}, 64'(acc_q.size() - base), 64'(n_exp));
        idx = 0;
        nbad = 0;
        for (int y = ay; y < ye; y++) begin
            for (int x = ax; x < xe; x++) begin
                if (idx < n_exp) begin
                    b = rom_bit(15'(y * SW + x));
                    case (m)
                        MODE_COPY:   col = {12{b}};
                        MODE_INVERT: col = ~{12{b}};
                        default:     col = c;
                    endcase
                    exp_pix = {8'(x), 8'(y), col};
                    if (base + idx >= acc_q.size() || acc_q[base + idx] !== exp_pix) nbad++;
                    idx++;
                end
            end
        end
        check({tag, "_bad_pixels"}, 64'(nbad), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int t, dc, fw, base, d0, b0, w0;
    logic reached;
    int ex_x [4] = '{0, 0, 160, 10};
    int ex_y [4] = '{0, 0, 10, 120};
    int ex_w [4] = '{0, 5, 5, 5};
    int ex_h [4] = '{5, 0, 5, 5};

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_we", 64'(pix_bus.pix_we), 0);
        check("rst_pix_x", 64'(pix_bus.pix_x), 0);
        check("rst_pix_y", 64'(pix_bus.pix_y), 0);
        check("rst_pix_color", 64'(pix_bus.pix_color), 0);
        check("rst_bg_addr", 64'(bg_addr), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        // Full-screen FILL at full rate
        base = acc_q.size(); d0 = done_cnt;
        start_job(MODE_FILL, 0, 0, 160, 120, 12'hF00, t);
        fw = -1;
        for (int i = 0; i < 20 && fw < 0; i++) begin
            @(negedge clk);
            if (i == 0) check("fill_busy", 64'(busy), 1);
            if (pix_bus.pix_we) fw = cyc;
        end
        check("fill_first_we", 64'(fw), 64'(t + 2 + ROM_LAT));
        wait_done("fill", 25000, dc);
        check("fill_done_cyc", 64'(dc), 64'(t + 2 + ROM_LAT + 19200));
        check("fill_busy_at_done", 64'(busy), 0);
        repeat (2) @(negedge clk);
        check("fill_done_once", 64'(done_cnt - d0), 1);
        verify_rect("fill", base, 0, 0, 160, 120, MODE_FILL, 12'hF00, 19200);

        // COPY with random backpressure
        rmode = 1; hold_chk = 1'b1;
        base = acc_q.size(); d0 = done_cnt;
        start_job(MODE_COPY, 10, 5, 4, 3, 12'h000, t);
        wait_done("copy", 500, dc);
        repeat (2) @(negedge clk);
        check("copy_done_once", 64'(done_cnt - d0), 1);
        verify_rect("copy", base, 10, 5, 4, 3, MODE_COPY, 12'h000, 12);

        // Clipped INVERT
        base = acc_q.size(); d0 = done_cnt;
        start_job(MODE_INVERT, 150, 115, 20, 20, 12'h000, t);
        wait_done("inv", 1000, dc);
        repeat (2) @(negedge clk);
        rmode = 0; hold_chk = 1'b0;
        check("inv_done_once", 64'(done_cnt - d0), 1);
        verify_rect("inv", base, 150, 115, 20, 20, MODE_INVERT, 12'h000, 50);

        // Empty rectangles
        for (int k = 0; k < 4; k++) begin
            b0 = busy_cnt; w0 = we_cnt; d0 = done_cnt;
            start_job(MODE_FILL, ex_x[k], ex_y[k], ex_w[k], ex_h[k], 12'h0F0, t);
            @(negedge clk);
            check($sformatf("empty%0d_done_t1", k), 64'(done), 1);
            repeat (4) @(negedge clk);
            check($sformatf("empty%0d_no_busy", k), 64'(busy_cnt - b0), 0);
            check($sformatf("empty%0d_no_we", k), 64'(we_cnt - w0), 0);
            check($sformatf("empty%0d_done_once", k), 64'(done_cnt - d0), 1);
        end

        // Abort after 7 accepted pixels
        base = acc_q.size(); d0 = done_cnt;
        start_job(MODE_FILL, 20, 30, 16, 16, 12'h0A5, t);
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (acc_q.size() - base >= 6) begin
                reached = 1'b1;
                break;
            end
        end
        check("abort_reached", 64'(reached), 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 0);
        check("abort_we", 64'(pix_bus.pix_we), 0);
        repeat (4) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 0);
        verify_rect("abort", base, 20, 30, 16, 16, MODE_FILL, 12'h0A5, 7);

        base = acc_q.size(); d0 = done_cnt;
        start_job(MODE_FILL, 5, 6, 3, 2, 12'h123, t);
        wait_done("post_abort", 100, dc);
        repeat (2) @(negedge clk);
        check("post_abort_done_once", 64'(done_cnt - d0), 1);
        verify_rect("post_abort", base, 5, 6, 3, 2, MODE_FILL, 12'h123, 6);

        // Start while busy is ignored
        base = acc_q.size(); d0 = done_cnt;
        start_job(MODE_FILL, 0, 0, 8, 4, 12'h3C3, t);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; mode = MODE_COPY; x0 = 8'd100; w = 8'd2; h = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_start", 200, dc);
        repeat (3) @(negedge clk);
        check("busy_start_done_once", 64'(done_cnt - d0), 1);
        check("busy_start_idle", 64'(busy), 0);
        verify_rect("busy_start", base, 0, 0, 8, 4, MODE_FILL, 12'h3C3, 32);

        // Asynchronous reset mid-RUN
        start_job(MODE_FILL, 30, 40, 50, 50, 12'hABC, t);
        repeat (20) @(posedge clk);
        #3;
        check("rst_mid_pre_busy", 64'(busy), 1);
        resetn = 1'b0;
        #1;
        check("rst_mid_async",
              64'({busy, done, pix_bus.pix_we, pix_bus.pix_x, pix_bus.pix_y, pix_bus.pix_color, bg_addr}),
              64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        w0 = we_cnt;
        repeat (5) @(negedge clk);
        check("rst_mid_no_reissue", 64'(we_cnt - w0), 0);
        check("rst_mid_idle", 64'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
